fwd_regfile: RTL and testbench
==============================

FWD_REGFILE -- requirements
Module: fwd_regfile

Interface
REQ-001 Parameter XLEN, 32, data width.
REQ-002 Parameter NREG, 32, register count; AW = clog2(NREG).
REQ-003 Parameter NRP, 2, read-port count.
REQ-004 Parameter NSTG, 3, forwarding stages; index 0 is the youngest (EX).
REQ-005 Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- rd_en  in  NRP  per-port read request.
- rd_addr  in  NRP*AW  read addresses, port p at [p*AW +: AW].
- rd_data  out  NRP*XLEN  read data.
- fwd_bus  in  NSTG*(2+AW+XLEN)  per stage {we, rdy, waddr, wdata}; rdy=0 means value not yet produced.
- we, waddr, wdata  in  1/AW/XLEN  writeback port.
- hilo_fwd  in  NSTG*(2+2*XLEN)  per stage {hi_we, lo_we, hi, lo}.
- hi_we, lo_we, hi_i, lo_i  in  1/1/XLEN/XLEN  HI/LO write.
- hilo_rd  in  1  HI/LO read request.
- hi_o, lo_o  out  XLEN each  forwarded HI/LO.
- sb_set, sb_set_addr  in  1/AW  mark register pending (long-latency issue).
- sb_clr, sb_clr_addr  in  1/AW  clear pending bit (completion).
- hilo_busy_set, hilo_busy_clr  in  1/1  mul/div occupancy of HI/LO.
- stall_req  out  1  decode must hold.
- stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-006 The array shall be written on the rising clk edge when we=1 and waddr!=0; register 0 shall never change.
REQ-007 For rd_addr=0, rd_data shall be 0 and the port shall never stall.
REQ-008 For nonzero addresses, rd_data shall be chosen by priority: the lowest-index stage with we=1 and a matching waddr; then the writeback port (we=1, waddr match); then the array.
REQ-009 Read data shall be combinational, with zero-cycle latency.
REQ-010 hi_o shall select the lowest-index stage with hi_we=1, then hi_we/hi_i, then the hi register; lo_o likewise, independently.
REQ-011 Port p shall stall if rd_en[p]=1, the address is nonzero, and either condition holds:
- the selected stage has rdy=0;
- no stage matches and the scoreboard bit for the address is set.
REQ-012 A forward hit with rdy=1 shall override a set scoreboard bit.
REQ-013 stall_req shall be the OR of all port stalls and of (hilo_rd & hilo_busy).
REQ-014 The scoreboard (NREG bits) and hilo_busy shall update on clk:
- set asserts the bit, clear deasserts it;
- set and clear to the same address in the same cycle: set wins;
- sb_set_addr=0 shall be ignored.
REQ-015 hilo_busy_set and hilo_busy_clr together shall leave hilo_busy=1.
REQ-016 stall_cnt shall increment each cycle that stall_req=1 and saturate at 0xFFFFFFFF.
REQ-017 With rd_en=0, a port shall still output data but shall not contribute to stall_req.

Reset
REQ-018 rst=1 shall asynchronously clear all registers, hi, lo, the scoreboard, hilo_busy and stall_cnt to 0.
REQ-019 Resetting during a pending long-latency operation shall drop it; a later sb_clr for it is harmless.
REQ-020 Outputs under reset: rd_data and hi_o/lo_o reflect forwarding inputs over zeroed state; stall_req still evaluates the forward-bus rdy conditions.

Structure
REQ-021 Forward-bus field offsets, the stage-entry width (2+AW+XLEN) and the HI/LO entry width shall go in the shared defines header.
REQ-022 One sub-module, fwd_mux (one read port: priority select and stall term), shall be instantiated NRP times.

Verification
REQ-023 Write r5=0x11 via WB, next cycle read r5 on port 0 -> 0x11, stall_req=0.
REQ-024 Stage0 {we=1, rdy=1, r7, 0xAA} and stage2 {we=1, rdy=1, r7, 0xBB} -> rd_data=0xAA.
REQ-025 Stage0 {we=1, rdy=0, r3} with rd_en=1, rd_addr=3 -> stall_req=1; stall_cnt goes 0->1 after one edge.
REQ-026 sb_set r9, then read r9 with no forward hit -> stall; sb_set r9 and sb_clr r9 in one cycle -> bit stays 1; sb_clr alone -> stall clears next cycle.
REQ-027 hilo_busy_set, then hilo_rd=1 -> stall_req=1; assert rst mid-busy -> hilo_busy=0 and stall_req=0 immediately, hi_o=0.
REQ-028 Force stall_cnt=0xFFFFFFFE, hold a stall for 3 cycles -> stall_cnt=0xFFFFFFFF.

Source files
------------

// File: rtl/fwd_regfile_pkg.sv
// Shared definitions for the forwarding register file: field layout of the
// forward-bus and HI/LO-bus stage entries, entry widths and counter limits.
// Consumers: fwd_regfile (top), fwd_mux (per read port).
//
// Forward-bus stage entry, MSB first:  {we, rdy, waddr[AW-1:0], wdata[XLEN-1:0]}
// HI/LO-bus stage entry, MSB first:    {hi_we, lo_we, hi[XLEN-1:0], lo[XLEN-1:0]}
// Stage s occupies bits [s*ENTRY_W +: ENTRY_W]; stage 0 is the youngest (EX).
package fwd_regfile_pkg;

  // Default geometry, handy for benches and wrappers.
  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRP  = 2;
  localparam int DEF_NSTG = 3;

  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

  // ---- forward-bus stage entry -------------------------------------------
  function automatic int fwd_ent_w(input int aw, input int xlen);
    return 2 + aw + xlen;
  endfunction

  function automatic int fwd_wdata_off();
    return 0;
  endfunction

  function automatic int fwd_waddr_off(input int xlen);
    return xlen;
  endfunction

  function automatic int fwd_rdy_off(input int aw, input int xlen);
    return xlen + aw;
  endfunction

  function automatic int fwd_we_off(input int aw, input int xlen);
    return xlen + aw + 1;
  endfunction

  // ---- HI/LO-bus stage entry ---------------------------------------------
  function automatic int hilo_ent_w(input int xlen);
    return 2 + 2 * xlen;
  endfunction

  function automatic int hilo_lo_off();
    return 0;
  endfunction

  function automatic int hilo_hi_off(input int xlen);
    return xlen;
  endfunction

  function automatic int hilo_lo_we_off(input int xlen);
    return 2 * xlen;
  endfunction

  function automatic int hilo_hi_we_off(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/fwd_regfile_fwd_mux.sv
// fwd_mux: one read port of the forwarding register file. Picks the youngest
//   matching forward stage, else the writeback port, else the array value, and
//   raises a stall when the chosen producer is not ready or the register is
//   pending in the scoreboard.
// Latency: purely combinational, zero cycles.
// Backpressure: none of its own; 'stall' is the port's hold request to decode.
// Ports:
//   rd_en/rd_addr        read request and address
//   fwd_bus              all forward stages, packed per fwd_regfile_pkg layout
//   wb_we/wb_addr/wb_data writeback port (bypassed in the same cycle)
//   arr_data             array contents at rd_addr
//   sb_pend              scoreboard pending bit for rd_addr
//   rd_data/stall        selected data and stall term
module fwd_mux
  import fwd_regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NSTG = 3,
  localparam int FW  = fwd_ent_w(AW, XLEN)
) (
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  input  logic [NSTG*FW-1:0] fwd_bus,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  input  logic [XLEN-1:0]    arr_data,
  input  logic               sb_pend,
  output logic [XLEN-1:0]    rd_data,
  output logic               stall
);

  logic            hit;
  logic            hit_rdy;
  logic [XLEN-1:0] hit_data;
  logic            addr_zero;

  // Walk oldest to youngest so the lowest-index match is the last write.
  always_comb begin
    hit      = 1'b0;
    hit_rdy  = 1'b0;
    hit_data = '0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (fwd_bus[s*FW + fwd_we_off(AW, XLEN)] &&
          (fwd_bus[s*FW + fwd_waddr_off(XLEN) +: AW] == rd_addr)) begin
        hit      = 1'b1;
        hit_rdy  = fwd_bus[s*FW + fwd_rdy_off(AW, XLEN)];
        hit_data = fwd_bus[s*FW + fwd_wdata_off() +: XLEN];
      end
    end
  end

  assign addr_zero = (rd_addr == '0);

  always_comb begin
    rd_data = arr_data;
    if (addr_zero) begin
      rd_data = '0;
    end else if (hit) begin
      rd_data = hit_data;
    end else if (wb_we && (wb_addr == rd_addr)) begin
      rd_data = wb_data;
    end
  end

  // A stage hit decides readiness on its own: a ready forward value is newer
  // than whatever the scoreboard is waiting on, so it overrides a pending bit.
  assign stall = rd_en && !addr_zero && (hit ? !hit_rdy : sb_pend);

endmodule

// File: rtl/fwd_regfile.sv
// fwd_regfile: NREG x XLEN register file with multi-stage operand forwarding,
//   HI/LO registers with their own forwarding, a pending-register scoreboard,
//   HI/LO busy tracking and a saturating stall-cycle counter.
// Latency: reads and forwarding are combinational (zero cycles); writes,
//   scoreboard and busy updates take effect on the next rising clk.
// Backpressure: stall_req asks decode to hold; it is the OR of per-port
//   stalls and (hilo_rd & hilo_busy). The block itself never refuses writes.
// Ports:
//   clk, rst                      clock, async active-high reset
//   rd_en/rd_addr/rd_data         NRP read ports, port p at [p*W +: W]
//   fwd_bus                       NSTG forward stages {we, rdy, waddr, wdata}
//   we/waddr/wdata                writeback port
//   hilo_fwd                      NSTG HI/LO stages {hi_we, lo_we, hi, lo}
//   hi_we/lo_we/hi_i/lo_i         HI/LO write
//   hilo_rd, hi_o, lo_o           HI/LO read request and forwarded values
//   sb_set*/sb_clr*               scoreboard mark/clear for long-latency ops
//   hilo_busy_set/clr             mul/div occupancy of HI/LO
//   stall_req, stall_cnt          hold request and saturating stall count
module fwd_regfile
  import fwd_regfile_pkg::*;
#(
  parameter int          XLEN          = 32,
  parameter int          NREG          = 32,
  parameter int          NRP           = 2,
  parameter int          NSTG          = 3,
  // Reset value of the stall counter; nonzero only for counter bring-up.
  parameter logic [31:0] STALL_CNT_RST = 32'h0,
  localparam int         AW            = $clog2(NREG),
  localparam int         FW            = fwd_ent_w(AW, XLEN),
  localparam int         HW            = hilo_ent_w(XLEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRP-1:0]       rd_en,
  input  logic [NRP*AW-1:0]    rd_addr,
  output logic [NRP*XLEN-1:0]  rd_data,
  input  logic [NSTG*FW-1:0]   fwd_bus,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [NSTG*HW-1:0]   hilo_fwd,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [XLEN-1:0]      hi_i,
  input  logic [XLEN-1:0]      lo_i,
  input  logic                 hilo_rd,
  output logic [XLEN-1:0]      hi_o,
  output logic [XLEN-1:0]      lo_o,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_clr,
  input  logic [AW-1:0]        sb_clr_addr,
  input  logic                 hilo_busy_set,
  input  logic                 hilo_busy_clr,
  output logic                 stall_req,
  output logic [31:0]          stall_cnt
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [NREG-1:0] sb_q, sb_d;
  logic            hilo_busy_q, hilo_busy_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;

  logic [NRP-1:0]  port_stall;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Register 0 is hardwired: only nonzero addresses are ever written.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_comb begin
    hi_d = hi_we ? hi_i : hi_q;
    lo_d = lo_we ? lo_i : lo_q;
  end

  // Clear first so a same-cycle set to the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (sb_clr) begin
      sb_d[sb_clr_addr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != '0)) begin
      sb_d[sb_set_addr] = 1'b1;
    end
  end

  always_comb begin
    hilo_busy_d = hilo_busy_q;
    if (hilo_busy_set) begin
      hilo_busy_d = 1'b1;
    end else if (hilo_busy_clr) begin
      hilo_busy_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_req && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q      <= '{default: '0};
      hi_q        <= '0;
      lo_q        <= '0;
      sb_q        <= '0;
      hilo_busy_q <= 1'b0;
      stall_cnt_q <= STALL_CNT_RST;
    end else begin
      regs_q      <= regs_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      sb_q        <= sb_d;
      hilo_busy_q <= hilo_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic [AW-1:0] addr_p;
    assign addr_p = rd_addr[p*AW +: AW];

    fwd_mux #(
      .XLEN (XLEN),
      .AW   (AW),
      .NSTG (NSTG)
    ) u_fwd_mux (
      .rd_en    (rd_en[p]),
      .rd_addr  (addr_p),
      .fwd_bus  (fwd_bus),
      .wb_we    (we),
      .wb_addr  (waddr),
      .wb_data  (wdata),
      .arr_data (regs_q[addr_p]),
      .sb_pend  (sb_q[addr_p]),
      .rd_data  (rd_data[p*XLEN +: XLEN]),
      .stall    (port_stall[p])
    );
  end

  // ---------------------------------------------------------------------------
  // HI/LO forwarding: youngest stage first, then the direct write, then the
  // register. HI and LO resolve independently (a stage may write only one).
  // ---------------------------------------------------------------------------
  always_comb begin
    hi_o = hi_we ? hi_i : hi_q;
    lo_o = lo_we ? lo_i : lo_q;
    for (int s = NSTG - 1; s >= 0; s--) begin
      if (hilo_fwd[s*HW + hilo_hi_we_off(XLEN)]) begin
        hi_o = hilo_fwd[s*HW + hilo_hi_off(XLEN) +: XLEN];
      end
      if (hilo_fwd[s*HW + hilo_lo_we_off(XLEN)]) begin
        lo_o = hilo_fwd[s*HW + hilo_lo_off() +: XLEN];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stall
  // ---------------------------------------------------------------------------
  assign stall_req = (|port_stall) || (hilo_rd && hilo_busy_q);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_regfile.sv
module tb_fwd_regfile;
  import fwd_regfile_pkg::*;

  localparam int XLEN = DEF_XLEN;
  localparam int NREG = DEF_NREG;
  localparam int NRP  = DEF_NRP;
  localparam int NSTG = DEF_NSTG;
  localparam int AW   = $clog2(NREG);
  localparam int FW   = 2 + AW + XLEN;
  localparam int HW   = 2 + 2 * XLEN;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRP-1:0]      rd_en;
  logic [NRP*AW-1:0]   rd_addr;
  logic [NRP*XLEN-1:0] rd_data, rd_data_s;
  logic [NSTG*FW-1:0]  fwd_bus;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NSTG*HW-1:0]  hilo_fwd;
  logic                hi_we, lo_we;
  logic [XLEN-1:0]     hi_i, lo_i;
  logic                hilo_rd;
  logic [XLEN-1:0]     hi_o, lo_o, hi_o_s, lo_o_s;
  logic                sb_set, sb_clr;
  logic [AW-1:0]       sb_set_addr, sb_clr_addr;
  logic                hilo_busy_set, hilo_busy_clr;
  logic                stall_req, stall_req_s;
  logic [31:0]         stall_cnt, stall_cnt_s;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  fwd_regfile dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .fwd_bus(fwd_bus), .we(we), .waddr(waddr), .wdata(wdata),
    .hilo_fwd(hilo_fwd), .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
    .hilo_rd(hilo_rd), .hi_o(hi_o), .lo_o(lo_o),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_clr(sb_clr), .sb_clr_addr(sb_clr_addr),
    .hilo_busy_set(hilo_busy_set), .hilo_busy_clr(hilo_busy_clr),
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  // Second instance whose counter resets near the top, for saturation.
  fwd_regfile #(.STALL_CNT_RST(32'hFFFF_FFFE)) dut_sat (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_s),
    .fwd_bus(fwd_bus), .we(we), .waddr(waddr), .wdata(wdata),
    .hilo_fwd(hilo_fwd), .hi_we(hi_we), .lo_we(lo_we), .hi_i(hi_i), .lo_i(lo_i),
    .hilo_rd(hilo_rd), .hi_o(hi_o_s), .lo_o(lo_o_s),
    .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_clr(sb_clr), .sb_clr_addr(sb_clr_addr),
    .hilo_busy_set(hilo_busy_set), .hilo_busy_clr(hilo_busy_clr),
    .stall_req(stall_req_s), .stall_cnt(stall_cnt_s)
  );

  // ---- scoreboard ----------------------------------------------------------
  localparam int S_RD0 = 0, S_RD1 = 1, S_STALL = 2, S_CNT = 3, S_HI = 4, S_LO = 5, S_CNT_SAT = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
    exp_q.push_back('{tag, sel, v});
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_RD0:     return rd_data[31:0];
      S_RD1:     return rd_data[63:32];
      S_STALL:   return {31'd0, stall_req};
      S_CNT:     return stall_cnt;
      S_HI:      return hi_o;
      S_LO:      return lo_o;
      S_CNT_SAT: return stall_cnt_s;
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Let combinational outputs settle, then compare everything queued.
  task automatic settle_check();
    exp_t        e;
    logic [31:0] o;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---- stimulus helpers ----------------------------------------------------
  task automatic set_fwd(input int s, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    fwd_bus[s*FW +: FW] = {w, r, a, d};
  endtask

  task automatic set_hilo(input int s, input logic hw, input logic lw,
                          input logic [XLEN-1:0] h, input logic [XLEN-1:0] l);
    hilo_fwd[s*HW +: HW] = {hw, lw, h, l};
  endtask

  task automatic set_rd(input int p, input logic en, input logic [AW-1:0] a);
    rd_en[p]           = en;
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  initial begin
    rst = 1'b1;
    rd_en = '0; rd_addr = '0; fwd_bus = '0; we = 1'b0; waddr = '0; wdata = '0;
    hilo_fwd = '0; hi_we = 1'b0; lo_we = 1'b0; hi_i = '0; lo_i = '0; hilo_rd = 1'b0;
    sb_set = 1'b0; sb_set_addr = '0; sb_clr = 1'b0; sb_clr_addr = '0;
    hilo_busy_set = 1'b0; hilo_busy_clr = 1'b0;

    // Reset state
    tick();
    push_exp("rst_stall", S_STALL, 32'd0);
    push_exp("rst_cnt", S_CNT, 32'd0);
    push_exp("rst_cnt_sat", S_CNT_SAT, 32'hFFFF_FFFE);
    push_exp("rst_hi", S_HI, 32'd0);
    push_exp("rst_rd0", S_RD0, 32'd0);
    settle_check();
    tick();
    rst = 1'b0;
    tick();

    // Writeback to r5, same-cycle bypass then array read
    we = 1'b1; waddr = 5'd5; wdata = 32'h11;
    set_rd(0, 1'b1, 5'd5);
    push_exp("wb_bypass_r5", S_RD0, 32'h11);
    settle_check();
    tick();
    we = 1'b0; wdata = '0;
    push_exp("arr_r5", S_RD0, 32'h11);
    push_exp("arr_r5_stall", S_STALL, 32'd0);
    settle_check();

    // r0 is hardwired to zero
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEAD_BEEF;
    tick();
    we = 1'b0;
    set_rd(0, 1'b1, 5'd0);
    push_exp("r0_zero", S_RD0, 32'd0);
    settle_check();

    // Forward priority: stage0 over stage2 over writeback over array
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'hAA);
    set_fwd(2, 1'b1, 1'b1, 5'd7, 32'hBB);
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b0, 5'd7);
    push_exp("fwd_s0_over_s2", S_RD0, 32'hAA);
    push_exp("fwd_rd_en0_data", S_RD1, 32'hAA);
    push_exp("fwd_s0_stall", S_STALL, 32'd0);
    settle_check();
    set_fwd(0, 1'b0, 1'b1, 5'd7, 32'hAA);
    we = 1'b1; waddr = 5'd7; wdata = 32'hCC;
    push_exp("fwd_s2_over_wb", S_RD0, 32'hBB);
    settle_check();
    set_fwd(2, 1'b0, 1'b1, 5'd7, 32'hBB);
    push_exp("wb_over_arr", S_RD0, 32'hCC);
    settle_check();
    we = 1'b0;
    fwd_bus = '0;

    // Fill r1..r31 and read back through port 1
    for (int i = 1; i < NREG; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = pat(i);
      tick();
    end
    we = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      set_rd(1, 1'b1, AW'(i));
      push_exp($sformatf("arr_r%0d", i), S_RD1, pat(i));
      settle_check();
      tick();
    end
    set_rd(1, 1'b0, 5'd0);
    push_exp("cnt_before_stall", S_CNT, 32'd0);
    settle_check();

    // Forward stage not ready -> stall, counter steps once per edge
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h99);
    set_rd(0, 1'b1, 5'd3);
    push_exp("nrdy_stall", S_STALL, 32'd1);
    push_exp("nrdy_cnt0", S_CNT, 32'd0);
    settle_check();
    tick();
    push_exp("nrdy_cnt1", S_CNT, 32'd1);
    settle_check();
    set_rd(0, 1'b0, 5'd3);
    push_exp("nrdy_rd_en0", S_STALL, 32'd0);
    settle_check();
    set_rd(1, 1'b1, 5'd3);
    push_exp("nrdy_port1", S_STALL, 32'd1);
    settle_check();
    set_rd(1, 1'b0, 5'd0);
    set_rd(0, 1'b1, 5'd0);
    push_exp("nrdy_addr0", S_STALL, 32'd0);
    settle_check();
    fwd_bus = '0;

    // Scoreboard
    set_rd(0, 1'b0, 5'd9);
    sb_set = 1'b1; sb_set_addr = 5'd9;
    tick();
    sb_set = 1'b0;
    set_rd(0, 1'b1, 5'd9);
    push_exp("sb_pend_stall", S_STALL, 32'd1);
    settle_check();
    set_fwd(1, 1'b1, 1'b1, 5'd9, 32'h55);
    push_exp("sb_fwd_override", S_STALL, 32'd0);
    push_exp("sb_fwd_data", S_RD0, 32'h55);
    settle_check();
    fwd_bus = '0;
    sb_set = 1'b1; sb_set_addr = 5'd9; sb_clr = 1'b1; sb_clr_addr = 5'd9;
    tick();
    sb_set = 1'b0; sb_clr = 1'b0;
    push_exp("sb_set_wins", S_STALL, 32'd1);
    settle_check();
    sb_clr = 1'b1; sb_clr_addr = 5'd9;
    tick();
    sb_clr = 1'b0;
    push_exp("sb_cleared", S_STALL, 32'd0);
    push_exp("sb_cnt3", S_CNT, 32'd3);
    settle_check();
    sb_set = 1'b1; sb_set_addr = 5'd0;
    tick();
    sb_set = 1'b0;
    push_exp("sb_r0_ignored", S_STALL, 32'd0);
    settle_check();
    set_rd(0, 1'b0, 5'd0);

    // HI/LO forwarding
    set_hilo(1, 1'b1, 1'b0, 32'h111, 32'hF1);
    set_hilo(2, 1'b1, 1'b1, 32'h222, 32'h333);
    push_exp("hi_s1", S_HI, 32'h111);
    push_exp("lo_s2", S_LO, 32'h333);
    settle_check();
    hilo_fwd = '0;
    hi_we = 1'b1; hi_i = 32'h444; lo_we = 1'b1; lo_i = 32'h555;
    push_exp("hi_direct", S_HI, 32'h444);
    push_exp("lo_direct", S_LO, 32'h555);
    settle_check();
    tick();
    hi_we = 1'b0; lo_we = 1'b0; hi_i = '0; lo_i = '0;
    push_exp("hi_reg", S_HI, 32'h444);
    push_exp("lo_reg", S_LO, 32'h555);
    settle_check();

    // HI/LO busy and reset mid-busy
    hilo_busy_set = 1'b1;
    tick();
    hilo_busy_set = 1'b0;
    hilo_rd = 1'b1;
    push_exp("hilo_busy_stall", S_STALL, 32'd1);
    settle_check();
    hilo_busy_set = 1'b1; hilo_busy_clr = 1'b1;
    sb_set = 1'b1; sb_set_addr = 5'd12;
    tick();
    hilo_busy_set = 1'b0; hilo_busy_clr = 1'b0; sb_set = 1'b0;
    set_rd(0, 1'b1, 5'd12);
    push_exp("hilo_setclr_busy", S_STALL, 32'd1);
    settle_check();
    rst = 1'b1;
    push_exp("rst_async_stall", S_STALL, 32'd0);
    push_exp("rst_async_hi", S_HI, 32'd0);
    push_exp("rst_async_lo", S_LO, 32'd0);
    push_exp("rst_async_cnt", S_CNT, 32'd0);
    push_exp("rst_async_rd0", S_RD0, 32'd0);
    settle_check();
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h0);
    set_rd(0, 1'b1, 5'd3);
    set_hilo(0, 1'b1, 1'b0, 32'h77, 32'h0);
    push_exp("rst_fwd_stall", S_STALL, 32'd1);
    push_exp("rst_fwd_hi", S_HI, 32'h77);
    push_exp("rst_fwd_lo", S_LO, 32'd0);
    settle_check();
    fwd_bus = '0; hilo_fwd = '0;
    set_rd(0, 1'b1, 5'd12);
    tick();
    rst = 1'b0;
    push_exp("post_rst_stall", S_STALL, 32'd0);
    push_exp("post_rst_cnt", S_CNT, 32'd0);
    push_exp("post_rst_cnt_sat", S_CNT_SAT, 32'hFFFF_FFFE);
    push_exp("post_rst_r12", S_RD0, 32'd0);
    settle_check();
    sb_clr = 1'b1; sb_clr_addr = 5'd9;
    tick();
    sb_clr = 1'b0;
    hilo_rd = 1'b0;
    push_exp("late_clr_harmless", S_STALL, 32'd0);
    settle_check();

    // Counter saturation
    set_fwd(0, 1'b1, 1'b0, 5'd3, 32'h0);
    set_rd(0, 1'b1, 5'd3);
    tick();
    push_exp("sat_cnt_1", S_CNT_SAT, 32'hFFFF_FFFF);
    push_exp("cnt_1", S_CNT, 32'd1);
    settle_check();
    tick();
    tick();
    push_exp("sat_cnt_3", S_CNT_SAT, 32'hFFFF_FFFF);
    push_exp("cnt_3", S_CNT, 32'd3);
    settle_check();
    fwd_bus = '0;
    rd_en = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
